except_arbiter: RTL



---
 rtl/except_pkg.sv | 33 +++
 rtl/except_prio_enc.sv | 33 +++
 rtl/except_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/except_pkg.sv
// -----------------------------------------------------------------------------
// except_pkg
// Shared definitions for the memory-stage exception arbiter:
//   - arb_state_e : IDLE / REPORT / FLUSH sequencing states
//   - EXC_INT     : excepttype value reported for an interrupt
//   - EXC_*       : synchronous exception codes carried on the source lanes
// -----------------------------------------------------------------------------
package except_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPORT = 2'd1,
        FLUSH  = 2'd2
    } arb_state_e;

    localparam logic [31:0] EXC_INT = 32'h0000_0001;

    localparam logic [4:0] EXC_ADEL        = 5'h04;
    localparam logic [4:0] EXC_ADES        = 5'h05;
    localparam logic [4:0] EXC_SYS         = 5'h08;
    localparam logic [4:0] EXC_BP          = 5'h09;
    localparam logic [4:0] EXC_RI          = 5'h0a;
    localparam logic [4:0] EXC_CPU         = 5'h0b;
    localparam logic [4:0] EXC_OV          = 5'h0c;
    localparam logic [4:0] EXC_TR          = 5'h0d;
    localparam logic [4:0] EXC_ERET        = 5'h0e;
    localparam logic [4:0] EXC_TLBL_REFILL = 5'h10;
    localparam logic [4:0] EXC_TLBL        = 5'h11;
    localparam logic [4:0] EXC_TLBS_REFILL = 5'h12;
    localparam logic [4:0] EXC_TLBS        = 5'h13;
    localparam logic [4:0] EXC_TLB_MOD     = 5'h14;

endpackage

// File: rtl/except_prio_enc.sv
// -----------------------------------------------------------------------------
// except_prio_enc
// Combinational find-first over the eligible source bits. Index 0 wins.
// Ports:
//   elig  in  NUM_SRC         eligible-source bits
//   codes in  NUM_SRC*CODE_W  packed codes, source i at [i*CODE_W +: CODE_W]
//   hit   out 1               at least one source eligible
//   code  out CODE_W          code of the lowest-index eligible source (0 if none)
// -----------------------------------------------------------------------------
module except_prio_enc #(
    parameter int NUM_SRC = 16,
    parameter int CODE_W  = 5
) (
    input  logic [NUM_SRC-1:0]        elig,
    input  logic [NUM_SRC*CODE_W-1:0] codes,
    output logic                      hit,
    output logic [CODE_W-1:0]         code
);

    // Scan from the lowest priority upwards so the last match (lowest index)
    // is the one that sticks.
    always_comb begin
        hit  = 1'b0;
        code = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                hit  = 1'b1;
                code = codes[i*CODE_W +: CODE_W];
            end
        end
    end

endmodule

// File: rtl/except_arbiter.sv
// -----------------------------------------------------------------------------
// except_arbiter
// Registered memory-stage exception arbiter. Picks the highest-priority cause
// (interrupt, then source 0 .. NUM_SRC-1), captures it with EPC / BD / BadVAddr,
// offers it to CP0 over valid/ready, then drives a FLUSH_CYCLES-long flush.
// m_stall is held from capture until the flush completes.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   m_valid, m_pc                 memory-stage instruction valid / PC
//   m_in_delay_slot, m_badvaddr   delay-slot flag, faulting address
//   src_valid, src_code           per-source requests and packed codes
//   cp0_status, cp0_cause         for interrupt pending (IM/IP, EXL, IE)
//   except_ready                  CP0 accepted the report
//   except_valid, excepttype      report valid, zero-extended code (1 = int)
//   except_epc, except_bd         EPC and Cause.BD to write
//   except_badvaddr               captured bad address
//   m_stall, flush                pipeline freeze / flush
//   exc_count, int_count          (EXCEPT_ARB_COUNT_EN only) accepted-report
//                                 and accepted-interrupt counters
//
// Optional feature macro: EXCEPT_ARB_COUNT_EN
// -----------------------------------------------------------------------------
module except_arbiter
    import except_pkg::*;
#(
    parameter int NUM_SRC      = 16,
    parameter int CODE_W       = 5,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m_valid,
    input  logic [31:0]               m_pc,
    input  logic                      m_in_delay_slot,
    input  logic [31:0]               m_badvaddr,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*CODE_W-1:0] src_code,
    input  logic [31:0]               cp0_status,
    input  logic [31:0]               cp0_cause,
    input  logic                      except_ready,
    output logic                      except_valid,
    output logic [31:0]               excepttype,
    output logic [31:0]               except_epc,
    output logic                      except_bd,
    output logic [31:0]               except_badvaddr,
    output logic                      m_stall,
`ifdef EXCEPT_ARB_COUNT_EN
    output logic [31:0]               exc_count,
    output logic [31:0]               int_count,
`endif
    output logic                      flush
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         type_q, type_d;
    logic [31:0]         epc_q, epc_d;
    logic                bd_q, bd_d;
    logic [31:0]         badv_q, badv_d;

    logic [NUM_SRC-1:0]  elig;
    logic                src_hit;
    logic [CODE_W-1:0]   src_sel_code;
    logic                int_pend;
    logic                take;
    logic                handshake;

    // Bits of the CP0 registers that play no part in arbitration.
    logic                unused_cp0;
    assign unused_cp0 = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};

    // A valid source carrying code 0 is not a real request.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_elig
            assign elig[gi] = src_valid[gi] & (|src_code[gi*CODE_W +: CODE_W]);
        end
    endgenerate

    except_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .CODE_W  (CODE_W)
    ) u_prio_enc (
        .elig  (elig),
        .codes (src_code),
        .hit   (src_hit),
        .code  (src_sel_code)
    );

    assign int_pend  = (|(cp0_cause[15:8] & cp0_status[15:8])) & ~cp0_status[1] & cp0_status[0];
    assign take      = m_valid & (int_pend | src_hit);
    assign handshake = (state_q == REPORT) & except_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        epc_d   = epc_q;
        bd_d    = bd_q;
        badv_d  = badv_q;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = REPORT;
                    type_d  = int_pend ? EXC_INT : {{(32-CODE_W){1'b0}}, src_sel_code};
                    epc_d   = m_in_delay_slot ? (m_pc - 32'd4) : m_pc;
                    bd_d    = m_in_delay_slot;
                    badv_d  = m_badvaddr;
                end
            end
            REPORT: begin
                // Captured report is frozen until CP0 takes it.
                if (except_ready) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    type_d  = '0;
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            type_q  <= '0;
            epc_q   <= '0;
            bd_q    <= 1'b0;
            badv_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            epc_q   <= epc_d;
            bd_q    <= bd_d;
            badv_q  <= badv_d;
        end
    end

`ifdef EXCEPT_ARB_COUNT_EN
    logic [31:0] exc_cnt_q, exc_cnt_d;
    logic [31:0] int_cnt_q, int_cnt_d;

    always_comb begin
        exc_cnt_d = exc_cnt_q;
        int_cnt_d = int_cnt_q;
        if (handshake) begin
            exc_cnt_d = exc_cnt_q + 32'd1;
            if (type_q == EXC_INT) begin
                int_cnt_d = int_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_cnt_q <= '0;
            int_cnt_q <= '0;
        end else begin
            exc_cnt_q <= exc_cnt_d;
            int_cnt_q <= int_cnt_d;
        end
    end

    assign exc_count = exc_cnt_q;
    assign int_count = int_cnt_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

    assign except_valid    = (state_q == REPORT);
    assign flush           = (state_q == FLUSH);
    assign m_stall         = (state_q != IDLE);
    assign excepttype      = type_q;
    assign except_epc      = epc_q;
    assign except_bd       = bd_q;
    assign except_badvaddr = badv_q;

endmodule
